svc_axi_latency_monitor: RTL and testbench

// - Passive AXI4 bus monitor that counts outstanding read bursts and write bursts.
// - Measures per-channel response stall time and flags protocol errors as sticky bits.
// - Generalises bounded-latency tracking to MAX_OUTSTANDING bursts per channel.
// - Checks each read burst's beat count against its ARLEN.
// - Sits between a master and svc_axi_mem, or any AXI slave, in formal harnesses and sim benches.
//

---
 rtl/svc_axi_latency_monitor.sv | 160 ++++++++++++++++
 tb/tb_svc_axi_latency_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_axi_latency_monitor.sv
// Passive AXI4 monitor: outstanding burst counts, response stall timers and sticky protocol flags.
// Optional formal hooks (assume bounded slave latency, assert no errors) via SVC_AXI_LATMON_FORMAL_EN.
module svc_axi_latency_monitor #(
    parameter int AXI_ID_WIDTH    = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RD_WAIT_MAX     = 4,
    parameter int WR_WAIT_MAX     = 2,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int RW = (RD_WAIT_MAX > 0) ? $clog2(RD_WAIT_MAX + 1) : 1,
    localparam int WW = (WR_WAIT_MAX > 0) ? $clog2(WR_WAIT_MAX + 1) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arvalid,
    input  logic          arready,
    input  logic [7:0]    arlen,
    input  logic          rvalid,
    input  logic          rready,
    input  logic          rlast,
    input  logic          awvalid,
    input  logic          awready,
    input  logic          bvalid,
    input  logic          bready,
    output logic [CW-1:0] rd_outstanding,
    output logic [CW-1:0] wr_outstanding,
    output logic [RW-1:0] rd_wait_count,
    output logic [WW-1:0] wr_wait_count,
    output logic          rd_stall_max,
    output logic          wr_stall_max,
    output logic          rd_proto_err,
    output logic          wr_proto_err,
    output logic          ovf_err
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [RW-1:0] RD_MAX_C = RW'(RD_WAIT_MAX);
    localparam logic [WW-1:0] WR_MAX_C = WW'(WR_WAIT_MAX);

    if (AXI_ID_WIDTH < 1 || MAX_OUTSTANDING < 1 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_param
        $error("svc_axi_latency_monitor: invalid parameters");
    end

    logic [7:0]    len_q [MAX_OUTSTANDING];
    logic [7:0]    len_d [MAX_OUTSTANDING];
    logic [PW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [7:0]    rd_beat_q, rd_beat_d;
    logic [CW-1:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
    logic [RW-1:0] rd_wait_q, rd_wait_d;
    logic [WW-1:0] wr_wait_q, wr_wait_d;
    logic          rd_err_q, rd_err_d, wr_err_q, wr_err_d, ovf_q, ovf_d;

    logic ar_hs, r_hs, aw_hs, b_hs;
    logic rd_empty, rd_full, wr_empty, wr_full;
    logic rd_push, rd_pop, wr_push, wr_pop;
    logic [7:0] head;

    always_comb begin
        ar_hs    = arvalid && arready;
        r_hs     = rvalid && rready;
        aw_hs    = awvalid && awready;
        b_hs     = bvalid && bready;
        rd_empty = (rd_out_q == '0);
        rd_full  = (rd_out_q == MAX_C);
        wr_empty = (wr_out_q == '0);
        wr_full  = (wr_out_q == MAX_C);
        head     = len_q[rd_rptr_q];
        rd_pop   = r_hs && rlast && !rd_empty;
        wr_pop   = b_hs && !wr_empty;
        // A push into a full channel is legal only when a pop frees the slot in the same cycle.
        rd_push  = ar_hs && (!rd_full || rd_pop);
        wr_push  = aw_hs && (!wr_full || wr_pop);

        len_d     = len_q;
        rd_wptr_d = rd_wptr_q;
        rd_rptr_d = rd_rptr_q;
        rd_beat_d = rd_beat_q;
        rd_err_d  = rd_err_q;
        wr_err_d  = wr_err_q;
        ovf_d     = ovf_q;

        if (r_hs) begin
            if (rd_empty) begin
                rd_err_d = 1'b1;
            end else begin
                if (rlast != (rd_beat_q == head)) rd_err_d = 1'b1;
                rd_beat_d = rlast ? '0 : rd_beat_q + 8'd1;
            end
        end
        if (b_hs && wr_empty) wr_err_d = 1'b1;
        if ((ar_hs && !rd_push) || (aw_hs && !wr_push)) ovf_d = 1'b1;

        if (rd_push) begin
            len_d[rd_wptr_q] = arlen;
            rd_wptr_d = (rd_wptr_q == LAST_PTR) ? '0 : rd_wptr_q + 1'b1;
        end
        if (rd_pop) rd_rptr_d = (rd_rptr_q == LAST_PTR) ? '0 : rd_rptr_q + 1'b1;

        rd_out_d = rd_out_q + CW'(rd_push) - CW'(rd_pop);
        wr_out_d = wr_out_q + CW'(wr_push) - CW'(wr_pop);

        // Stall timers look at the pre-update counts.
        if (r_hs || rd_empty)        rd_wait_d = '0;
        else if (rd_wait_q == RD_MAX_C) rd_wait_d = RD_MAX_C;
        else                         rd_wait_d = rd_wait_q + 1'b1;
        if (b_hs || wr_empty)        wr_wait_d = '0;
        else if (wr_wait_q == WR_MAX_C) wr_wait_d = WR_MAX_C;
        else                         wr_wait_d = wr_wait_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_q     <= '{default: '0};
            rd_wptr_q <= '0;
            rd_rptr_q <= '0;
            rd_beat_q <= '0;
            rd_out_q  <= '0;
            wr_out_q  <= '0;
            rd_wait_q <= '0;
            wr_wait_q <= '0;
            rd_err_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            len_q     <= len_d;
            rd_wptr_q <= rd_wptr_d;
            rd_rptr_q <= rd_rptr_d;
            rd_beat_q <= rd_beat_d;
            rd_out_q  <= rd_out_d;
            wr_out_q  <= wr_out_d;
            rd_wait_q <= rd_wait_d;
            wr_wait_q <= wr_wait_d;
            rd_err_q  <= rd_err_d;
            wr_err_q  <= wr_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rd_outstanding = rd_out_q;
    assign wr_outstanding = wr_out_q;
    assign rd_wait_count  = rd_wait_q;
    assign wr_wait_count  = wr_wait_q;
    assign rd_stall_max   = (rd_wait_q == RD_MAX_C);
    assign wr_stall_max   = (wr_wait_q == WR_MAX_C);
    assign rd_proto_err   = rd_err_q;
    assign wr_proto_err   = wr_err_q;
    assign ovf_err        = ovf_q;

`ifdef SVC_AXI_LATMON_FORMAL_EN
    // Bounded slave latency keeps liveness properties provable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (rd_out_q != '0) assume (rd_wait_q < RD_MAX_C);
            if (wr_out_q != '0) assume (wr_wait_q < WR_MAX_C);
            assert (!rd_err_q && !wr_err_q && !ovf_q);
        end
    end
`endif
endmodule

// File: tb/tb_svc_axi_latency_monitor.sv
// Directed and randomized bench for svc_axi_latency_monitor against a queue-based reference model.
module tb_svc_axi_latency_monitor;
    localparam int MAXO = 4;
    localparam int RDM  = 4;
    localparam int WRM  = 2;

    logic clock = 1'b0;
    logic reset, arvalid, arready, rvalid, rready, rlast, awvalid, awready, bvalid, bready;
    logic [7:0] arlen;
    logic [2:0] rd_outstanding, wr_outstanding, rd_wait_count;
    logic [1:0] wr_wait_count;
    logic rd_stall_max, wr_stall_max, rd_proto_err, wr_proto_err, ovf_err;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    int rdq[$];
    int rd_beat_m, wr_cnt_m, rd_wait_m, wr_wait_m;
    bit rd_err_m, wr_err_m, ovf_m;

    svc_axi_latency_monitor #(
        .AXI_ID_WIDTH(2), .MAX_OUTSTANDING(MAXO), .RD_WAIT_MAX(RDM), .WR_WAIT_MAX(WRM)
    ) dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .bvalid(bvalid), .bready(bready),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .rd_wait_count(rd_wait_count), .wr_wait_count(wr_wait_count),
        .rd_stall_max(rd_stall_max), .wr_stall_max(wr_stall_max),
        .rd_proto_err(rd_proto_err), .wr_proto_err(wr_proto_err), .ovf_err(ovf_err)
    );

    always #5 clock = ~clock;

    function automatic void chk(string tag, int got, int exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_step();
        bit ar, r, aw, b, pop, bpop;
        int rd_n;
        if (reset) begin
            rdq.delete();
            rd_beat_m = 0; wr_cnt_m = 0; rd_wait_m = 0; wr_wait_m = 0;
            rd_err_m = 0; wr_err_m = 0; ovf_m = 0;
            return;
        end
        ar = arvalid && arready; r = rvalid && rready;
        aw = awvalid && awready; b = bvalid && bready;
        rd_n = rdq.size();
        pop = 0;
        if (r) begin
            if (rd_n == 0) rd_err_m = 1;
            else begin
                if (rlast != (rd_beat_m == rdq[0])) rd_err_m = 1;
                if (rlast) pop = 1;
                else rd_beat_m = (rd_beat_m + 1) % 256;
            end
        end
        rd_wait_m = (r || rd_n == 0) ? 0 : min2(rd_wait_m + 1, RDM);
        if (pop) begin
            void'(rdq.pop_front());
            rd_beat_m = 0;
        end
        if (ar) begin
            if (rd_n == MAXO && !pop) ovf_m = 1;
            else rdq.push_back(int'(arlen));
        end
        bpop = b && wr_cnt_m > 0;
        if (b && wr_cnt_m == 0) wr_err_m = 1;
        wr_wait_m = (b || wr_cnt_m == 0) ? 0 : min2(wr_wait_m + 1, WRM);
        if (aw) begin
            if (wr_cnt_m == MAXO && !bpop) ovf_m = 1;
            else wr_cnt_m++;
        end
        if (bpop) wr_cnt_m--;
    endfunction

    function automatic void check_all(string tag);
        chk({tag, ".rd_out"}, int'(rd_outstanding), rdq.size());
        chk({tag, ".wr_out"}, int'(wr_outstanding), wr_cnt_m);
        chk({tag, ".rd_wait"}, int'(rd_wait_count), rd_wait_m);
        chk({tag, ".wr_wait"}, int'(wr_wait_count), wr_wait_m);
        chk({tag, ".rd_stall"}, int'(rd_stall_max), int'(rd_wait_m == RDM));
        chk({tag, ".wr_stall"}, int'(wr_stall_max), int'(wr_wait_m == WRM));
        chk({tag, ".rd_err"}, int'(rd_proto_err), int'(rd_err_m));
        chk({tag, ".wr_err"}, int'(wr_proto_err), int'(wr_err_m));
        chk({tag, ".ovf"}, int'(ovf_err), int'(ovf_m));
    endfunction

    task automatic idle();
        reset = 0; arvalid = 0; arready = 0; arlen = '0; rvalid = 0; rready = 0;
        rlast = 0; awvalid = 0; awready = 0; bvalid = 0; bready = 0;
    endtask

    task automatic step(string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step("rst");
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        step("rst0");
        step("rst1");
        chk("reset.rd_out", int'(rd_outstanding), 0);
        chk("reset.ovf", int'(ovf_err), 0);

        // Well-formed 4-beat burst
        idle(); arvalid = 1; arready = 1; arlen = 8'd3;
        step("t1.ar");
        chk("t1.rd_out_after_ar", int'(rd_outstanding), 1);
        idle(); rvalid = 1; rready = 1;
        for (int i = 0; i < 4; i++) begin
            rlast = (i == 3);
            step("t1.r");
            chk("t1.rd_wait", int'(rd_wait_count), 0);
        end
        idle();
        chk("t1.rd_out_done", int'(rd_outstanding), 0);
        chk("t1.rd_err", int'(rd_proto_err), 0);

        // Early rlast is a sticky error
        arvalid = 1; arready = 1; arlen = 8'd1;
        step("t2.ar");
        idle(); rvalid = 1; rready = 1; rlast = 1;
        step("t2.r");
        chk("t2.rd_err", int'(rd_proto_err), 1);
        idle();
        for (int i = 0; i < 3; i++) step("t2.hold");
        chk("t2.rd_err_sticky", int'(rd_proto_err), 1);
        do_reset();

        // Read stall timer and saturation
        arvalid = 1; arready = 1; arlen = 8'd0;
        step("t3.ar");
        idle();
        for (int k = 1; k <= 5; k++) begin
            step("t3.idle");
            chk("t3.rd_wait", int'(rd_wait_count), min2(k, RDM));
            chk("t3.rd_stall", int'(rd_stall_max), int'(k >= RDM));
        end
        rvalid = 1; rready = 1; rlast = 1;
        step("t3.r");
        idle();
        chk("t3.rd_wait_clr", int'(rd_wait_count), 0);
        chk("t3.rd_err", int'(rd_proto_err), 0);

        // Write channel fill, full-with-pop, overflow, drain
        awvalid = 1; awready = 1;
        for (int i = 0; i < 4; i++) step("t4.aw");
        chk("t4.wr_full", int'(wr_outstanding), 4);
        bvalid = 1; bready = 1;
        step("t4.aw_b");
        chk("t4.wr_full_pop", int'(wr_outstanding), 4);
        chk("t4.no_ovf", int'(ovf_err), 0);
        bvalid = 0; bready = 0;
        step("t4.aw_ovf");
        chk("t4.ovf", int'(ovf_err), 1);
        chk("t4.wr_hold", int'(wr_outstanding), 4);
        idle(); bvalid = 1; bready = 1;
        for (int i = 0; i < 4; i++) step("t4.b");
        idle();
        chk("t4.wr_drained", int'(wr_outstanding), 0);
        do_reset();

        // Final R of A together with AR of B
        arvalid = 1; arready = 1; arlen = 8'd2;
        step("t5.arA");
        idle(); rvalid = 1; rready = 1;
        step("t5.r0");
        step("t5.r1");
        rlast = 1; arvalid = 1; arready = 1; arlen = 8'd1;
        step("t5.r2_arB");
        chk("t5.rd_out", int'(rd_outstanding), 1);
        idle(); rvalid = 1; rready = 1;
        step("t5.rB0");
        rlast = 1;
        step("t5.rB1");
        idle();
        chk("t5.rd_err", int'(rd_proto_err), 0);
        chk("t5.rd_out_done", int'(rd_outstanding), 0);

        // B with nothing outstanding
        bvalid = 1; bready = 1;
        step("t6.b");
        idle();
        chk("t6.wr_err", int'(wr_proto_err), 1);

        // Reset mid-burst
        arvalid = 1; arready = 1; arlen = 8'd3; awvalid = 1; awready = 1;
        step("t7.ar_aw");
        idle(); rvalid = 1; rready = 1;
        step("t7.r");
        idle(); reset = 1;
        step("t7.rst");
        chk("t7.rd_out", int'(rd_outstanding), 0);
        chk("t7.wr_out", int'(wr_outstanding), 0);
        chk("t7.wr_err", int'(wr_proto_err), 0);
        reset = 0;
        step("t7.after");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 199) == 0);
            arvalid = ($urandom_range(0, 2) == 0);
            arready = $urandom_range(0, 1);
            arlen   = 8'($urandom_range(0, 3));
            rvalid  = $urandom_range(0, 1);
            rready  = $urandom_range(0, 1);
            if (rdq.size() > 0 && $urandom_range(0, 15) != 0) rlast = (rd_beat_m == rdq[0]);
            else rlast = $urandom_range(0, 1);
            awvalid = ($urandom_range(0, 2) == 0);
            awready = $urandom_range(0, 1);
            bvalid  = ($urandom_range(0, 3) == 0);
            bready  = $urandom_range(0, 1);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
